// File: rtl/signal_gen_pkg.sv
// Shared state encoding and constants for the signal generator controller.
package signal_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC_P,
        CALC_H,
        RUN,
        DONE
    } state_e;

    localparam int DIV_W_DEF = 34;
    localparam int PCT_MAX   = 100;
    // Two divisions, the RUN entry cycle and the sig_out register.
    localparam int START_LAT = 2 * (DIV_W_DEF + 1) + 2;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle: load on start_i, done_o pulses W cycles later.
module seq_divider #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  quot_q, rem_q, dvsr_q;
    logic [CW-1:0] cnt_q;
    logic          run_q, done_q;
    logic [W:0]    trial;
    logic [W-1:0]  diff;
    logic          ge;

    // When ge holds the true difference fits in W bits, so modulo-2^W subtraction is exact.
    always_comb begin
        trial = {rem_q, quot_q[W-1]};
        ge    = (trial >= {1'b0, dvsr_q});
        diff  = trial[W-1:0] - dvsr_q;
    end

    // NOTE: non-blocking assignments only in clocked blocks, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quot_q <= dividend_i;
                rem_q  <= '0;
                dvsr_q <= divisor_i;
                cnt_q  <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                quot_q <= {quot_q[W-2:0], ge};
                rem_q  <= ge ? diff : trial[W-1:0];
                cnt_q  <= cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/signal_gen_ctrl.sv
// Burst/continuous square-wave generator with divider-derived period and duty.
// Optional complementary output sig_out_n when SIGNAL_GEN_COMPL_OUT_EN is defined.
module signal_gen_ctrl
    import signal_gen_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [25:0] freq,
    input  logic [7:0]  duty,
    input  logic [15:0] burst,
    output logic        sig_out,
`ifdef SIGNAL_GEN_COMPL_OUT_EN
    output logic        sig_out_n,
`endif
    output logic        busy,
    output logic        finish,
    output logic        cfg_err
);

    localparam logic [DIV_W-1:0] CLK_DIV  = DIV_W'(CLK_FREQ);
    localparam logic [DIV_W-1:0] HALF_CLK = DIV_W'(CLK_FREQ / 2);

    state_e           state_q, state_d;
    logic [7:0]       duty_q;
    logic [15:0]      burst_q, periods_q, periods_d;
    logic [DIV_W-1:0] period_q, high_q, phase_q, phase_d;
    logic             sig_out_q, sig_out_d, busy_q, busy_d, finish_q, cfg_err_q, cfg_err_d;
    logic             div_start, div_done;
    logic [DIV_W-1:0] div_dividend, div_divisor, div_quot, div_rem_unused, prod;
    logic             freq_bad, wrap, high_now;

    assign freq_bad = (freq == '0) || (DIV_W'(freq) > HALF_CLK);
    assign prod     = div_quot * DIV_W'(duty_q);
    assign wrap     = (phase_q == period_q - DIV_W'(1));
    assign high_now = (phase_q < high_q);

    seq_divider #(.W(DIV_W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem_unused)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        periods_d    = periods_q;
        div_start    = 1'b0;
        div_dividend = CLK_DIV;
        div_divisor  = DIV_W'(freq);
        cfg_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (freq_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d   = CALC_P;
                        div_start = 1'b1;
                        phase_d   = '0;
                        periods_d = '0;
                    end
                end
            end
            CALC_P: begin
                div_dividend = prod;
                div_divisor  = DIV_W'(PCT_MAX);
                if (stop) begin
                    state_d = DONE;
                end else if (div_done) begin
                    state_d   = CALC_H;
                    div_start = 1'b1;
                end
            end
            CALC_H: begin
                if (stop)          state_d = DONE;
                else if (div_done) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = DONE;
                end else if (wrap) begin
                    phase_d   = '0;
                    periods_d = periods_q + 16'd1;
                    if (burst_q != '0 && periods_d == burst_q) state_d = DONE;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A stop seen in RUN drops the wave on the very next edge.
    assign sig_out_d = (state_q == RUN) && !stop && high_now;
    assign busy_d    = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            burst_q   <= '0;
            periods_q <= '0;
            period_q  <= '0;
            high_q    <= '0;
            phase_q   <= '0;
            sig_out_q <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            periods_q <= periods_d;
            sig_out_q <= sig_out_d;
            busy_q    <= busy_d;
            finish_q  <= (state_q == DONE);
            cfg_err_q <= cfg_err_d;
            if (state_q == IDLE && state_d == CALC_P) begin
                duty_q  <= (duty > 8'(PCT_MAX)) ? 8'(PCT_MAX) : duty;
                burst_q <= burst;
            end
            if (state_q == CALC_P && state_d == CALC_H) period_q <= div_quot;
            if (state_q == CALC_H && state_d == RUN)    high_q   <= div_quot;
        end
    end

`ifdef SIGNAL_GEN_COMPL_OUT_EN
    logic sig_out_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_out_n_q <= 1'b0;
        else        sig_out_n_q <= (state_q == RUN) && !stop && !high_now;
    end

    assign sig_out_n = sig_out_n_q;
`endif

    assign sig_out = sig_out_q;
    assign busy    = busy_q;
    assign finish  = finish_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Table-driven bench for signal_gen_ctrl: per-cycle expected outputs flow through a scoreboard queue.
module tb_signal_gen_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [25:0] freq = '0;
    logic [7:0]  duty = '0;
    logic [15:0] burst = '0;
    logic        sig_out, busy, finish, cfg_err;
`ifdef SIGNAL_GEN_COMPL_OUT_EN
    logic        sig_out_n;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        string       name;
        logic [25:0] f;
        logic [7:0]  d;
        logic [15:0] b;
        int          p;
        int          h;
        bit          err;
        int          stop_at;
        int          restart_at;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    signal_gen_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .freq      (freq),
        .duty      (duty),
        .burst     (burst),
        .sig_out   (sig_out),
`ifdef SIGNAL_GEN_COMPL_OUT_EN
        .sig_out_n (sig_out_n),
`endif
        .busy      (busy),
        .finish    (finish),
        .cfg_err   (cfg_err)
    );

    function automatic vec_t mk(string name, int f, int d, int b, int p, int h,
                                bit err, int stop_at, int restart_at);
        vec_t v;
        v.name = name;  v.f = 26'(f);  v.d = 8'(d);  v.b = 16'(b);
        v.p = p;  v.h = h;  v.err = err;  v.stop_at = stop_at;  v.restart_at = restart_at;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0b, expected %0b", name, cyc, got, exp);
        end
    endtask

    // Cycle 0 is the start cycle; cycle k is sampled 1 time unit after the k-th rising edge.
    task automatic run_case(input vec_t v);
        int         d_b, dd, last_sig, n, first_hi;
        bit         stopped, sig_e;
        logic [3:0] got, e;
        d_b      = (v.b != 0) ? 71 + v.p * int'(v.b) : 1_000_000;
        stopped  = (v.stop_at != 0) && (v.stop_at + 1 <= d_b);
        dd       = stopped ? v.stop_at + 1 : d_b;
        last_sig = stopped ? dd - 1 : dd;
        n        = v.err ? 3 : dd + 2;
        first_hi = -1;
        start = 1'b1;  freq = v.f;  duty = v.d;  burst = v.b;
        for (int k = 1; k <= n; k++) begin
            sig_e = !v.err && k >= 72 && k <= last_sig && ((k - 72) % v.p) < v.h;
            exp_q.push_back(v.err ? {3'b000, k == 1} : {sig_e, k <= dd, k == dd + 1, 1'b0});
            @(posedge clk); #1;
            start = 1'b0;
            stop  = (k == v.stop_at);
            if (k == v.restart_at) begin
                start = 1'b1;  freq = 26'd1_000_000;  duty = 8'd25;  burst = 16'd3;
            end
            got = {sig_out, busy, finish, cfg_err};
            e   = exp_q.pop_front();
            check({v.name, " {sig_out,busy,finish,cfg_err}"}, k, int'(got), int'(e));
            if (got[3] && first_hi < 0) first_hi = k;
`ifdef SIGNAL_GEN_COMPL_OUT_EN
            check({v.name, " sig_out_n"}, k, int'(sig_out_n),
                  int'(!v.err && k >= 72 && k <= last_sig && !sig_e));
`endif
        end
        start = 1'b0;
        stop  = 1'b0;
        if (!v.err && v.h > 0 && last_sig >= 72)
            check({v.name, " first-edge latency"}, 0, first_hi, 72);
    endtask

    initial begin
        vecs.push_back(mk("burst3_d25",    1_000_000,  25, 3, 50,   12,  0, 0,    0));
        vecs.push_back(mk("freq_zero",     0,          50, 1, 1,    0,   1, 0,    0));
        vecs.push_back(mk("freq_30M",      30_000_000, 50, 1, 1,    0,   1, 0,    0));
        vecs.push_back(mk("freq_half_p1",  25_000_001, 50, 1, 1,    0,   1, 0,    0));
        vecs.push_back(mk("duty0",         1_000_000,  0,  2, 50,   0,   0, 0,    0));
        vecs.push_back(mk("duty150",       1_000_000,  150,2, 50,   50,  0, 0,    0));
        vecs.push_back(mk("freq_half",     25_000_000, 50, 4, 2,    1,   0, 0,    0));
        vecs.push_back(mk("f3M_d33",       3_000_000,  33, 2, 16,   5,   0, 0,    0));
        vecs.push_back(mk("f7M_d100",      7_000_000,  100,1, 7,    7,   0, 0,    0));
        vecs.push_back(mk("f49999_d37",    49_999,     37, 1, 1000, 370, 0, 0,    0));
        vecs.push_back(mk("cont_stop",     5_000_000,  50, 0, 10,   5,   0, 1001, 0));
        vecs.push_back(mk("stop_on_wrap",  25_000_000, 50, 1, 2,    1,   0, 72,   0));
        vecs.push_back(mk("stop_calc_p",   1_000_000,  25, 3, 50,   12,  0, 20,   0));
        vecs.push_back(mk("stop_calc_h",   1_000_000,  25, 3, 50,   12,  0, 60,   0));

        #12;
        check("reset state", 0, int'({sig_out, busy, finish, cfg_err}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // stop while idle must not disturb anything
        stop = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("stop in idle", k, int'({sig_out, busy, finish, cfg_err}), 0);
        end
        stop = 1'b0;

        foreach (vecs[i]) run_case(vecs[i]);

        // Reset mid-RUN: outputs clear without waiting for a clock edge.
        start = 1'b1;  freq = 26'd1_000_000;  duty = 8'd25;  burst = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        check("pre-reset sig_out/busy", 80, int'({sig_out, busy}), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", 80, int'({sig_out, busy, finish, cfg_err}), 0);
`ifdef SIGNAL_GEN_COMPL_OUT_EN
        check("async reset sig_out_n", 80, int'(sig_out_n), 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            check("idle after reset", k, int'({sig_out, busy, finish, cfg_err}), 0);
        end
        run_case(mk("restart_in_calc_h", 3_000_000, 33, 2, 16, 5, 0, 0, 50));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/signal_gen_ctrl.md
SIGNAL_GEN_CTRL -- requirements
Module: signal_gen_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, SHALL give the system clock frequency in Hz.
REQ-002 Parameter DIV_W, default 34, SHALL give the sequential divider width in bits.
REQ-003 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  launches one generation run when high and busy is low.
REQ-006 stop  input  1  aborts a run in progress.
REQ-007 freq  input  26  target output frequency in Hz, sampled at start.
REQ-008 duty  input  8  target duty cycle in percent, sampled at start.
REQ-009 burst  input  16  number of periods to emit, sampled at start; 0 means continuous.
REQ-010 sig_out  output  1  generated square wave, registered.
REQ-011 busy  output  1  high from the accepted start until the cycle finish pulses.
REQ-012 finish  output  1  one-clk pulse at the end of a run, either completed or stopped.
REQ-013 cfg_err  output  1  one-clk pulse when a start is rejected.

Function
REQ-014 FSM states SHALL be IDLE, CALC_P, CALC_H, RUN and DONE; reset state is IDLE.
REQ-015 IDLE: start=1 SHALL latch freq, duty and burst, set busy, and go to CALC_P; start while busy SHALL be ignored.
REQ-016 freq==0 or freq>CLK_FREQ/2 at start SHALL pulse cfg_err for 1 cycle, leave busy low and stay in IDLE.
REQ-017 duty>100 SHALL be clamped to 100.
REQ-018 CALC_P SHALL compute period=floor(CLK_FREQ/freq) with the sequential divider, taking exactly DIV_W+1 cycles.
REQ-019 CALC_H SHALL compute high=floor(period*duty/100) with the same divider in DIV_W+1 cycles; the product is 34 bits wide with no truncation.
REQ-020 The first sig_out rising edge SHALL occur exactly 2*(DIV_W+1)+2 cycles after the start cycle when high>0.
REQ-021 RUN: a phase counter SHALL run from 0 to period-1 and wrap; sig_out SHALL be 1 while counter<high, else 0.
REQ-022 high==0 SHALL hold sig_out low for the whole run; high==period SHALL hold sig_out high for the whole run.
REQ-023 Each counter wrap SHALL increment the completed-period count; when the count equals a nonzero burst, the FSM SHALL go to DONE in that cycle.
REQ-024 DONE SHALL force sig_out to 0, pulse finish for 1 cycle, clear busy in that same cycle, and return to IDLE.
REQ-025 stop in CALC_P, CALC_H or RUN SHALL go to DONE on the next edge, with no partial period completed.
REQ-026 stop in IDLE SHALL have no effect.
REQ-027 stop and a burst completion in the same cycle SHALL produce a single finish pulse.

Reset
REQ-028 Asserting rst_n low SHALL immediately force sig_out=0, busy=0, finish=0 and cfg_err=0, clear all counters and the divider, and select IDLE, including mid-run.
REQ-029 After rst_n deasserts, the block SHALL need a new start before generating.

Configuration
REQ-030 With macro SIGNAL_GEN_COMPL_OUT_EN defined, an extra output sig_out_n (1 bit, registered, =~sig_out in RUN, 0 outside RUN and during reset) SHALL exist.
REQ-031 Without SIGNAL_GEN_COMPL_OUT_EN, the sig_out_n port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 A shared package signal_gen_pkg SHALL hold the FSM state enum, DIV_W_DEF=34, PCT_MAX=100 and the startup-latency constant.
REQ-033 Division SHALL be done by one sub-module, seq_divider: restoring, one quotient bit per cycle, with start/done handshake and quotient/remainder outputs, reused for both CALC_P and CALC_H.

Verification
REQ-034 CLK_FREQ=50M, freq=1_000_000, duty=25, burst=3 -> period=50, high=12; exactly 3 periods of 12 high / 38 low; finish 1 cycle after the third wrap.
REQ-035 freq=0, then freq=30_000_000 -> cfg_err pulse each time, busy never high, sig_out stays 0.
REQ-036 duty=0, and separately duty=150 (clamped to 100), with burst=2 -> sig_out constant 0 and constant 1 respectively for 100 cycles, then finish.
REQ-037 burst=0 at freq=5_000_000, stop after 1000 cycles -> continuous 10-cycle period (duty 50 -> 5/5) until stop, sig_out 0 next edge, single finish pulse.
REQ-038 rst_n low mid-RUN, then start during CALC_H -> outputs cleared immediately; the second start is ignored and the run uses its original parameters.
REQ-039 Start-to-first-edge latency -> measured as exactly 72 cycles for DIV_W=34; with SIGNAL_GEN_COMPL_OUT_EN defined, sig_out_n is the exact complement throughout RUN.
